// File: rtl/cpu_step_clock_gen.sv
// Step/free-run clock-enable generator for the single-cycle CPU (debounced key, 2-flop synchronisers).
// Optional retired-step counter enabled by defining STEP_COUNTER_EN; otherwise step_count is tied to 0.
module cpu_step_clock_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_step_n,
  input  logic             run_mode,
  input  logic             halt,
  output logic             step_en,
  output logic             running,
  output logic             halted,
  output logic             key_clean,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    ST_STEP   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             key_meta, key_sync;
  logic             mode_meta, mode_sync;
  logic [DB_W-1:0]  db_cnt;
  logic             key_clean_d;
  logic [DIV_W-1:0] div, div_next;
  logic             step_en_next;
  logic             key_mismatch_c;
  logic             press_c;

  // Two-flop synchronisers; the key idles released (high), the mode switch idles single-step
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta  <= 1'b1;
      key_sync  <= 1'b1;
      mode_meta <= 1'b0;
      mode_sync <= 1'b0;
    end else begin
      key_meta  <= key_step_n;
      key_sync  <= key_meta;
      mode_meta <= run_mode;
      mode_sync <= mode_meta;
    end
  end

  assign key_mismatch_c = (key_sync != key_clean);

  // Debounce: key_clean follows the synced key only after DEBOUNCE_CYCLES consecutive mismatches
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt      <= '0;
      key_clean   <= 1'b1;
      key_clean_d <= 1'b1;
    end else begin
      key_clean_d <= key_clean;
      if (!key_mismatch_c) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        key_clean <= key_sync;
        db_cnt    <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // One-cycle press event on the debounced falling edge
  assign press_c = key_clean_d & ~key_clean;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_STEP;
      div     <= '0;
      step_en <= 1'b0;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      state   <= state_next;
      div     <= div_next;
      step_en <= step_en_next;
      running <= (state_next == ST_RUN);
      halted  <= (state_next == ST_HALTED);
    end
  end

  // Halt overrides everything; a mode change in STEP takes precedence over a press
  always_comb begin
    state_next   = state;
    div_next     = '0;
    step_en_next = 1'b0;
    if (halt) begin
      state_next = ST_HALTED;
    end else begin
      case (state)
        ST_STEP: begin
          if (mode_sync) begin
            state_next = ST_RUN;
          end else if (press_c) begin
            step_en_next = 1'b1;
          end
        end
        ST_RUN: begin
          if (!mode_sync) begin
            state_next = ST_STEP;
          end else begin
            div_next     = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            step_en_next = (div == DIV_LAST);
          end
        end
        ST_HALTED: begin
          state_next = mode_sync ? ST_RUN : ST_STEP;
        end
        default: begin
          state_next = ST_STEP;
        end
      endcase
    end
  end

`ifdef STEP_COUNTER_EN
  // Retired-step counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      step_count <= '0;
    end else if (step_en) begin
      step_count <= step_count + CNT_W'(1);
    end
  end
`else
  assign step_count = '0;
`endif

endmodule

// File: tb/tb_cpu_step_clock_gen.sv
// Bench for cpu_step_clock_gen: directed scenarios plus random key/mode/halt/reset traffic,
// every cycle compared against an edge-indexed reference model.
module tb_cpu_step_clock_gen;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned CW  = 4;
  localparam int M_STEP = 0, M_RUN = 1, M_HALT = 2;

  logic          clk = 1'b0;
  logic          rst, key_step_n, run_mode, halt;
  logic          step_en, running, halted, key_clean;
  logic [CW-1:0] step_count;

  int unsigned n_vec = 0, n_err = 0;
  int          pulses = 0;

  // Reference model: sync delay lines, window of synced key samples, RUN entry edge index
  bit          m_kpipe[$];
  bit          m_mpipe[$];
  bit          m_win[$];
  bit          m_kc, m_press, m_step;
  int          m_state, m_t, m_run_start;
  int unsigned m_cnt;

  cpu_step_clock_gen #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV        (DIV),
    .CNT_W          (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_step_n(key_step_n),
    .run_mode  (run_mode),
    .halt      (halt),
    .step_en   (step_en),
    .running   (running),
    .halted    (halted),
    .key_clean (key_clean),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    bit ks, ms, press_pre, all_flip;
    m_t++;
    if (rst) begin
      m_kpipe = '{1'b1, 1'b1};
      m_mpipe = '{1'b0, 1'b0};
      m_win.delete();
      m_kc    = 1'b1;
      m_press = 1'b0;
      m_step  = 1'b0;
      m_state = M_STEP;
      m_cnt   = 0;
    end else begin
      ks = m_kpipe.pop_front();
      m_kpipe.push_back(key_step_n);
      ms = m_mpipe.pop_front();
      m_mpipe.push_back(run_mode);
      press_pre = m_press;
      m_step = 1'b0;
      if (halt) begin
        m_state = M_HALT;
      end else if (m_state == M_STEP) begin
        if (ms) begin
          m_state = M_RUN;
          m_run_start = m_t;
        end else if (press_pre) begin
          m_step = 1'b1;
        end
      end else if (m_state == M_RUN) begin
        if (!ms) m_state = M_STEP;
        else if ((m_t - m_run_start) % DIV == 0) m_step = 1'b1;
      end else begin
        m_state = ms ? M_RUN : M_STEP;
        m_run_start = m_t;
      end
      // key_clean flips once the last DB synced samples all disagree with it
      m_press = 1'b0;
      m_win.push_back(ks);
      if (m_win.size() > DB) void'(m_win.pop_front());
      all_flip = (m_win.size() == DB);
      foreach (m_win[i]) if (m_win[i] == m_kc) all_flip = 1'b0;
      if (all_flip) begin
        m_press = m_kc;
        m_kc = ~m_kc;
        m_win.delete();
      end
      if (m_step) m_cnt = (m_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic tick();
    logic [31:0] exp_cnt;
    @(posedge clk);
    model_edge();
    #1;
`ifdef STEP_COUNTER_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    check("step_en",    32'(step_en),   32'(m_step));
    check("running",    32'(running),   32'(m_state == M_RUN));
    check("halted",     32'(halted),    32'(m_state == M_HALT));
    check("key_clean",  32'(key_clean), 32'(m_kc));
    check("step_count", 32'(step_count), exp_cnt);
    if (step_en) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1; key_step_n = 1'b1; run_mode = 1'b0; halt = 1'b0;
    ticks(2);
    rst = 1'b0;
    ticks(8);

    // Clean press: step_en exactly DB+3 edges after the key goes low
    lat = 0;
    key_step_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_en && lat == 0) lat = i;
    end
    check("press_latency", 32'(lat), 32'(DB + 3));
    key_step_n = 1'b1;
    ticks(12);

    // Bounce shorter than the debounce window
    pulses = 0;
    key_step_n = 1'b0; ticks(3);
    key_step_n = 1'b1; ticks(1);
    key_step_n = 1'b0; ticks(2);
    key_step_n = 1'b1; ticks(12);
    check("bounce_pulses", 32'(pulses), 32'd0);

    // Free-run: 16 pulses wrap the counter, then back to single-step
    pulses = 0;
    run_mode = 1'b1;
    ticks(3 + 16 * DIV);
    check("run_pulses", 32'(pulses), 32'd16);
    pulses = 0;
    run_mode = 1'b0;
    ticks(20);
    check("run_stop_pulses", 32'(pulses), 32'd0);

    // Halt asserted on a pulse cycle, press while halted, then release
    run_mode = 1'b1;
    ticks(3);
    for (int i = 0; i < 20 && !step_en; i++) tick();
    check("run_pulse_seen", 32'(step_en), 32'd1);
    ticks(DIV - 1);
    halt = 1'b1;
    tick();
    check("halt_suppress", 32'(step_en), 32'd0);
    check("halt_state", 32'(halted), 32'd1);
    pulses = 0;
    key_step_n = 1'b0; ticks(12);
    key_step_n = 1'b1; ticks(12);
    check("halt_press_pulses", 32'(pulses), 32'd0);
    halt = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_en && lat == 0) lat = i;
    end
    check("halt_release_latency", 32'(lat), 32'(DIV + 1));
    run_mode = 1'b0;
    ticks(6);

    // Reset while the debounce counter is at 2
    key_step_n = 1'b0;
    ticks(4);
    rst = 1'b1; key_step_n = 1'b1;
    tick();
    rst = 1'b0;
    pulses = 0;
    ticks(12);
    check("rst_mid_db_pulses", 32'(pulses), 32'd0);
    check("rst_mid_db_key", 32'(key_clean), 32'd1);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        key_step_n = ~key_step_n;
      end else if (r < 55) begin
        run_mode = ~run_mode;
      end else if (r < 70) begin
        halt = 1'b1;
        ticks(int'($urandom_range(1, 4)));
        halt = 1'b0;
      end else if (r < 73) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      ticks(int'($urandom_range(1, 12)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
